multicycle_ctrl: RTL and testbench

//  Multicycle main control FSM, directly upstream of the ALU control decoder.

---
 rtl/multicycle_ctrl_pkg.sv | 60 ++++++
 rtl/multicycle_ctrl_out_decode.sv | 58 +++++
 rtl/multicycle_ctrl.sv | 133 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle main control FSM: opcodes, ALU-op codes
// (common with the downstream ALU control decoder), ALU B-source codes, state
// encodings and the strobe bundle.
package multicycle_ctrl_pkg;

  localparam int unsigned OP_W   = 6;
  localparam int unsigned ALU_W  = 2;
  localparam int unsigned SRCB_W = 2;
  localparam int unsigned ST_W   = 3;

  localparam logic [OP_W-1:0] OP_R    = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001100;
  localparam logic [OP_W-1:0] OP_SUBI = 6'b001101;
  localparam logic [OP_W-1:0] OP_SW   = 6'b010000;
  localparam logic [OP_W-1:0] OP_LW   = 6'b010001;

  localparam logic [ALU_W-1:0] ALU_ADD   = 2'b00;
  localparam logic [ALU_W-1:0] ALU_SUB   = 2'b01;
  localparam logic [ALU_W-1:0] ALU_RTYPE = 2'b10;

  localparam logic [SRCB_W-1:0] SRCB_REGB = 2'b00;
  localparam logic [SRCB_W-1:0] SRCB_FOUR = 2'b01;
  localparam logic [SRCB_W-1:0] SRCB_IMM  = 2'b10;

  typedef enum logic [ST_W-1:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_ADDR   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  // Datapath strobes driven by the controller
  typedef struct packed {
    logic              pc_we;
    logic              ir_we;
    logic              mem_rd;
    logic              mem_wr;
    logic              i_or_d;
    logic              alu_src_a;
    logic [SRCB_W-1:0] alu_src_b;
    logic [ALU_W-1:0]  alu_op;
    logic              reg_dst;
    logic              mem_to_reg;
    logic              reg_we;
  } strobes_t;

  // Opcodes that take the EXEC path
  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return (op == OP_R) || (op == OP_ADDI) || (op == OP_SUBI);
  endfunction

  // Opcodes that take the ADDR/MEM path
  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_out_decode.sv
// Combinational strobe decode for the multicycle controller.
// Ports:
//   state     in   current FSM state
//   op_q      in   opcode latched in DECODE
//   mem_ready in   memory handshake (only feeds ir_we/pc_we in FETCH)
//   strobes_c out  datapath strobe bundle
module multicycle_ctrl_out_decode
  import multicycle_ctrl_pkg::*;
(
  input  state_t          state,
  input  logic [OP_W-1:0] op_q,
  input  logic            mem_ready,
  output strobes_t        strobes_c
);

  // Map state/opcode to strobes; anything not set stays 0
  always_comb begin
    strobes_c        = '0;
    strobes_c.alu_op = ALU_ADD;
    case (state)
      S_FETCH: begin
        strobes_c.mem_rd    = 1'b1;
        strobes_c.alu_src_b = SRCB_FOUR;
        strobes_c.ir_we     = mem_ready;
        strobes_c.pc_we     = mem_ready;
      end
      S_EXEC: begin
        strobes_c.alu_src_a = 1'b1;
        if (op_q == OP_R) begin
          strobes_c.alu_src_b = SRCB_REGB;
          strobes_c.alu_op    = ALU_RTYPE;
        end else if (op_q == OP_SUBI) begin
          strobes_c.alu_src_b = SRCB_IMM;
          strobes_c.alu_op    = ALU_SUB;
        end else begin
          strobes_c.alu_src_b = SRCB_IMM;
          strobes_c.alu_op    = ALU_ADD;
        end
      end
      S_ADDR: begin
        strobes_c.alu_src_a = 1'b1;
        strobes_c.alu_src_b = SRCB_IMM;
      end
      S_MEM: begin
        strobes_c.i_or_d = 1'b1;
        strobes_c.mem_rd = (op_q == OP_LW);
        strobes_c.mem_wr = (op_q == OP_SW);
      end
      S_WB: begin
        strobes_c.reg_we     = 1'b1;
        strobes_c.reg_dst    = (op_q == OP_R);
        strobes_c.mem_to_reg = (op_q == OP_LW);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle main control FSM: FETCH/DECODE/EXEC|ADDR/MEM/WB sequencing,
// memory-ready stalls and a retired-instruction counter.
// Build option: define ILLEGAL_TRAP_EN to trap illegal opcodes in TRAP with a
// sticky illegal flag; otherwise illegal opcodes are NOPs and illegal is 0.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   opcode              IR[31:26], valid in DECODE
//   mem_ready           memory completes current access
//   pc_we .. reg_we     datapath strobes (all 0 during rst)
//   state_o             current state code
//   retired             completed-instruction count (wraps)
//   illegal             sticky illegal-opcode flag
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   opcode,
  input  logic              mem_ready,
  output logic              pc_we,
  output logic              ir_we,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              i_or_d,
  output logic              alu_src_a,
  output logic [SRCB_W-1:0] alu_src_b,
  output logic [ALU_W-1:0]  alu_op,
  output logic              reg_dst,
  output logic              mem_to_reg,
  output logic              reg_we,
  output logic [ST_W-1:0]   state_o,
  output logic [CNT_W-1:0]  retired,
  output logic              illegal
);

  state_t          state_q;
  state_t          state_d;
  logic [OP_W-1:0] op_q;
  logic            retire_c;
  strobes_t        strobes_c;
  strobes_t        strobes;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic and retire detection
  always_comb begin
    state_d  = state_q;
    retire_c = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (is_alu_op(opcode))      state_d = S_EXEC;
        else if (is_mem_op(opcode)) state_d = S_ADDR;
        else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_EXEC: state_d = S_WB;
      S_ADDR: state_d = S_MEM;
      S_MEM: begin
        if (mem_ready) begin
          if (op_q == OP_LW) begin
            state_d = S_WB;
          end else begin
            state_d  = S_FETCH;
            retire_c = (op_q == OP_SW);
          end
        end
      end
      S_WB: begin
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Opcode latch and retired counter
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      retired <= '0;
    end else begin
      if (state_q == S_DECODE) op_q <= opcode;
      if (retire_c)            retired <= retired + CNT_W'(1);
    end
  end

`ifdef ILLEGAL_TRAP_EN
  // Sticky flag, raised on entry to TRAP
  always_ff @(posedge clk) begin
    if (rst)                                           illegal <= 1'b0;
    else if (state_q == S_DECODE && state_d == S_TRAP) illegal <= 1'b1;
  end
`else
  assign illegal = 1'b0;
`endif

  multicycle_ctrl_out_decode u_out_decode (
    .state     (state_q),
    .op_q      (op_q),
    .mem_ready (mem_ready),
    .strobes_c (strobes_c)
  );

  // Reset kills every strobe immediately, before the state register clears
  assign strobes = rst ? '0 : strobes_c;

  assign pc_we      = strobes.pc_we;
  assign ir_we      = strobes.ir_we;
  assign mem_rd     = strobes.mem_rd;
  assign mem_wr     = strobes.mem_wr;
  assign i_or_d     = strobes.i_or_d;
  assign alu_src_a  = strobes.alu_src_a;
  assign alu_src_b  = strobes.alu_src_b;
  assign alu_op     = strobes.alu_op;
  assign reg_dst    = strobes.reg_dst;
  assign mem_to_reg = strobes.mem_to_reg;
  assign reg_we     = strobes.reg_we;
  assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction phase sequences
// built from opcode class and wait counts, compared cycle by cycle.
module tb_multicycle_ctrl;

  localparam int unsigned CW  = 4;
  localparam int          MOD = 1 << CW;

  localparam logic [5:0] R_OP = 6'b000000;
  localparam logic [5:0] ADDI = 6'b001100;
  localparam logic [5:0] SUBI = 6'b001101;
  localparam logic [5:0] SW   = 6'b010000;
  localparam logic [5:0] LW   = 6'b010001;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    opcode;
  logic          mem_ready;
  logic          pc_we, ir_we, mem_rd, mem_wr, i_or_d, alu_src_a;
  logic [1:0]    alu_src_b, alu_op;
  logic          reg_dst, mem_to_reg, reg_we;
  logic [2:0]    state_o;
  logic [CW-1:0] retired;
  logic          illegal;

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_we(pc_we), .ir_we(ir_we), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .i_or_d(i_or_d), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_we(reg_we), .state_o(state_o), .retired(retired), .illegal(illegal)
  );

  function automatic logic legal(input logic [5:0] op);
    return op == R_OP || op == ADDI || op == SUBI || op == SW || op == LW;
  endfunction

  // Expected {pc_we,ir_we,mem_rd,mem_wr,i_or_d,alu_src_a,alu_src_b,alu_op,reg_dst,mem_to_reg,reg_we}
  function automatic logic [12:0] exp_strobes(input int ph, input logic [5:0] op, input logic rdy);
    logic pw = 0, iw = 0, rd = 0, wr = 0, iod = 0, sa = 0, rdst = 0, m2r = 0, rwe = 0;
    logic [1:0] sb = 2'b00, ao = 2'b00;
    case (ph)
      0: begin rd = 1; sb = 2'b01; pw = rdy; iw = rdy; end
      2: begin
        sa = 1;
        if (op == R_OP)      begin sb = 2'b00; ao = 2'b10; end
        else if (op == ADDI) begin sb = 2'b10; ao = 2'b00; end
        else                 begin sb = 2'b10; ao = 2'b01; end
      end
      3: begin sa = 1; sb = 2'b10; end
      4: begin iod = 1; rd = (op == LW); wr = (op == SW); end
      5: begin rwe = 1; rdst = (op == R_OP); m2r = (op == LW); end
      default: ;
    endcase
    return {pw, iw, rd, wr, iod, sa, sb, ao, rdst, m2r, rwe};
  endfunction

  function automatic logic [12:0] act_strobes();
    return {pc_we, ir_we, mem_rd, mem_wr, i_or_d, alu_src_a, alu_src_b, alu_op,
            reg_dst, mem_to_reg, reg_we};
  endfunction

  // One cycle starting just after a posedge: drive, settle, compare, advance
  task automatic cycle(input int ph, input logic [5:0] op, input logic rdy,
                       input logic [5:0] drv_op, input string tag);
    logic [12:0] expv;
    opcode    = drv_op;
    mem_ready = rdy;
    #1;
    expv = exp_strobes(ph, op, rdy);
    checks++;
    if (state_o !== 3'(ph) || act_strobes() !== expv) begin
      errors++;
      $display("FAIL %s: state %0d strobes %b, expected state %0d strobes %b",
               tag, state_o, act_strobes(), ph, expv);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_retired(input string tag);
    checks++;
    if (retired !== CW'(exp_ret)) begin
      errors++;
      $display("FAIL %s retired: got %0d expected %0d", tag, retired, exp_ret);
    end
  endtask

  // Whole instruction from FETCH; fw/mw are wait cycles in FETCH/MEM
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input string tag);
    for (int i = 0; i <= fw; i++) cycle(0, op, i == fw, 6'($urandom), tag);
    cycle(1, op, 1'($urandom), op, tag);
    if (op == R_OP || op == ADDI || op == SUBI) begin
      cycle(2, op, 1'($urandom), 6'($urandom), tag);
      cycle(5, op, 1'($urandom), 6'($urandom), tag);
      exp_ret = (exp_ret + 1) % MOD;
    end else if (op == LW || op == SW) begin
      cycle(3, op, 1'($urandom), 6'($urandom), tag);
      for (int i = 0; i <= mw; i++) cycle(4, op, i == mw, 6'($urandom), tag);
      if (op == LW) cycle(5, op, 1'($urandom), 6'($urandom), tag);
      exp_ret = (exp_ret + 1) % MOD;
    end
    check_retired(tag);
  endtask

  task automatic apply_reset();
    rst = 1; mem_ready = 1; opcode = 6'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    exp_ret = 0;
  endtask

  task automatic test_reset();
    rst = 1; mem_ready = 1; opcode = 6'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (state_o !== 3'd0 || act_strobes() !== 13'd0 || retired !== '0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset: state %0d strobes %b retired %0d illegal %b, expected 0 0 0 0",
               state_o, act_strobes(), retired, illegal);
    end
    rst = 0;
    exp_ret = 0;
  endtask

  task automatic test_rtype();
    run_instr(R_OP, 0, 0, "rtype");
    run_instr(ADDI, 0, 0, "addi");
  endtask

  task automatic test_subi();
    run_instr(SUBI, 1, 0, "subi");
  endtask

  task automatic test_lw_wait();
    run_instr(LW, 0, 3, "lw_wait");
  endtask

  task automatic test_sw();
    run_instr(SW, 0, 0, "sw");
    run_instr(SW, 2, 2, "sw_wait");
  endtask

  task automatic test_reset_mid_lw();
    cycle(0, LW, 1, 6'h2a, "rst_lw");
    cycle(1, LW, 0, LW, "rst_lw");
    cycle(3, LW, 0, 6'h00, "rst_lw");
    cycle(4, LW, 0, 6'h00, "rst_lw");
    rst = 1; mem_ready = 1;
    #1;
    checks++;
    if (state_o !== 3'd4 || act_strobes() !== 13'd0 || retired !== CW'(exp_ret)) begin
      errors++;
      $display("FAIL rst_mid_lw during: state %0d strobes %b retired %0d, expected 4 0 %0d",
               state_o, act_strobes(), retired, exp_ret);
    end
    @(posedge clk); #1;
    rst = 0;
    exp_ret = 0;
    checks++;
    if (state_o !== 3'd0 || retired !== '0) begin
      errors++;
      $display("FAIL rst_mid_lw after: state %0d retired %0d, expected 0 0", state_o, retired);
    end
    run_instr(LW, 0, 0, "after_rst");
  endtask

  task automatic test_random();
    logic [5:0] op;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(5))
        0: op = R_OP;
        1: op = ADDI;
        2: op = SUBI;
        3: op = SW;
        4: op = LW;
        default: begin
`ifdef ILLEGAL_TRAP_EN
          op = ADDI;
`else
          do op = 6'($urandom); while (legal(op));
`endif
        end
      endcase
      run_instr(op, $urandom_range(2), $urandom_range(3), "random");
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 10; n++) run_instr((n % 2) ? SW : SUBI, 0, 0, "b2b");
  endtask

  task automatic test_illegal();
    int keep;
    keep = exp_ret;
`ifdef ILLEGAL_TRAP_EN
    cycle(0, 6'h3f, 1, 6'h00, "trap");
    cycle(1, 6'h3f, 1, 6'h3f, "trap");
    for (int i = 0; i < 4; i++) begin
      cycle(6, 6'h3f, 1'($urandom), 6'($urandom), "trap");
      checks++;
      if (illegal !== 1'b1 || retired !== CW'(keep)) begin
        errors++;
        $display("FAIL trap flag: illegal %b retired %0d, expected 1 %0d", illegal, retired, keep);
      end
    end
    apply_reset();
    checks++;
    if (illegal !== 1'b0 || state_o !== 3'd0) begin
      errors++;
      $display("FAIL trap clear: illegal %b state %0d, expected 0 0", illegal, state_o);
    end
`else
    run_instr(6'h3f, 0, 0, "illegal_nop");
    checks++;
    if (state_o !== 3'd0 || illegal !== 1'b0 || retired !== CW'(keep)) begin
      errors++;
      $display("FAIL illegal_nop: state %0d illegal %b retired %0d, expected 0 0 %0d",
               state_o, illegal, retired, keep);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_subi();
    test_lw_wait();
    test_sw();
    test_reset_mid_lw();
    test_back_to_back();
    test_random();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
